// File: rtl/demux_pkg.sv
// Shared types and constants for the 1:4 TDM demultiplexer: lane count, slot index, sync FSM states.
package demux_pkg;
  localparam int NUM_LANES = 4;

  typedef logic [1:0] slot_t;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } sync_state_t;

  localparam slot_t LANE_A = 2'd0;
  localparam slot_t LANE_B = 2'd1;
  localparam slot_t LANE_C = 2'd2;
  localparam slot_t LANE_D = 2'd3;
endpackage

// File: rtl/demux_lane.sv
// One-word lane holding register with valid/ready output and sticky overflow; write to dout in 1 clk.
// Backpressure: a write while full and not draining is dropped and sets ovf (set beats clr_ovf).
module demux_lane #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_ready,
  input  logic         clr_ovf,
  output logic [W-1:0] dout,
  output logic         dout_valid,
  output logic         ovf
);
  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic         ovf_q, ovf_d;
  logic         accept;

  always_comb begin
    // A full lane can take a new word only in the cycle its consumer drains it.
    accept  = wr_en && (!valid_q || rd_ready);
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (accept) begin
      data_d  = wr_data;
      valid_d = 1'b1;
    end else if (valid_q && rd_ready) begin
      valid_d = 1'b0;
    end
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end
    if (wr_en && !accept) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign dout       = data_q;
  assign dout_valid = valid_q;
  assign ovf        = ovf_q;
endmodule

// File: rtl/demux_1x4_tdm.sv
// 1:4 TDM demux: frame-synced slot counter routes each din word to lane A..D, din->dout 1 clk, per-lane drop+ovf.
// DEMUX_MANUAL_SEL_EN: lane chosen by {sl1,sl2}, FSM held LOCKED, frame_sync ignored, sync_err tied 0.
module demux_1x4_tdm
  import demux_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   din,
  input  logic           din_valid,
  input  logic           frame_sync,
  output logic [4*W-1:0] dout,
  output logic [3:0]     dout_valid,
  input  logic [3:0]     dout_ready,
  output logic [3:0]     ovf,
  input  logic           clr_ovf,
  output logic           sync_err,
  output logic           locked
`ifdef DEMUX_MANUAL_SEL_EN
  ,
  input  logic           sl1,
  input  logic           sl2
`endif
);
  sync_state_t state_q, state_d;
  slot_t       slot_q, slot_d;
  logic        sync_err_q, sync_err_d;
  logic        wr_vld;
  slot_t       lane;

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    sync_err_d = 1'b0;
    wr_vld     = 1'b0;
    lane       = LANE_A;
`ifdef DEMUX_MANUAL_SEL_EN
    state_d = LOCKED;
    wr_vld  = din_valid;
    lane    = {sl1, sl2};
`else
    case (state_q)
      HUNT: begin
        if (din_valid && frame_sync) begin
          wr_vld  = 1'b1;
          lane    = LANE_A;
          slot_d  = LANE_B;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (din_valid) begin
          lane       = frame_sync ? LANE_A : slot_q;
          wr_vld     = 1'b1;
          slot_d     = lane + slot_t'(1);
          sync_err_d = frame_sync && (slot_q != LANE_A);
        end else if (frame_sync) begin
          // A bare frame marker realigns without consuming a slot.
          slot_d = LANE_A;
        end
      end
      default: state_d = HUNT;
    endcase
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      slot_q     <= LANE_A;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign sync_err = sync_err_q;
  assign locked   = (state_q == LOCKED);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    demux_lane #(.W(W)) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (wr_vld && (lane == slot_t'(l))),
      .wr_data    (din),
      .rd_ready   (dout_ready[l]),
      .clr_ovf    (clr_ovf),
      .dout       (dout[l*W +: W]),
      .dout_valid (dout_valid[l]),
      .ovf        (ovf[l])
    );
  end
endmodule

// File: tb/tb_demux_1x4_tdm.sv
// Directed plus randomized bench for demux_1x4_tdm against a per-lane reference model.
module tb_demux_1x4_tdm;
  logic        clk;
  logic        rst_n;
  logic [7:0]  din;
  logic        din_valid;
  logic        frame_sync;
  logic [31:0] dout;
  logic [3:0]  dout_valid;
  logic [3:0]  dout_ready;
  logic [3:0]  ovf;
  logic        clr_ovf;
  logic        sync_err;
  logic        locked;
  logic        sl1;
  logic        sl2;

  int checks;
  int errors;

  logic [7:0] m_dat [4];
  bit         m_vld [4];
  bit         m_ovf [4];
  bit         m_locked;
  bit         m_serr;
  int         m_slot;

  demux_1x4_tdm #(.W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .ovf        (ovf),
    .clr_ovf    (clr_ovf),
    .sync_err   (sync_err),
    .locked     (locked)
`ifdef DEMUX_MANUAL_SEL_EN
    ,
    .sl1        (sl1),
    .sl2        (sl2)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < 4; l++) begin
      m_dat[l] = 8'h00;
      m_vld[l] = 1'b0;
      m_ovf[l] = 1'b0;
    end
    m_locked = 1'b0;
    m_serr   = 1'b0;
    m_slot   = 0;
  endtask

  task automatic compare_all();
    for (int l = 0; l < 4; l++) begin
      chk($sformatf("dout[%0d]", l), 32'(dout[l*8 +: 8]), 32'(m_dat[l]));
      chk($sformatf("dout_valid[%0d]", l), 32'(dout_valid[l]), 32'(m_vld[l]));
      chk($sformatf("ovf[%0d]", l), 32'(ovf[l]), 32'(m_ovf[l]));
    end
    chk("sync_err", 32'(sync_err), 32'(m_serr));
    chk("locked", 32'(locked), 32'(m_locked));
  endtask

  // Advance the model by one clock from the current inputs, clock the DUT, then compare.
  task automatic step();
    int ln;
    bit wr;
    ln = 0;
    wr = 1'b0;
    m_serr = 1'b0;
`ifdef DEMUX_MANUAL_SEL_EN
    if (din_valid) begin
      wr = 1'b1;
      ln = 2 * int'(sl1) + int'(sl2);
    end
    m_locked = 1'b1;
`else
    if (din_valid) begin
      if (!m_locked) begin
        if (frame_sync) begin
          wr = 1'b1;
          ln = 0;
          m_locked = 1'b1;
          m_slot = 1;
        end
      end else begin
        ln = frame_sync ? 0 : m_slot;
        m_serr = frame_sync && (m_slot != 0);
        m_slot = (ln + 1) % 4;
        wr = 1'b1;
      end
    end else if (frame_sync && m_locked) begin
      m_slot = 0;
    end
`endif
    if (clr_ovf) begin
      for (int l = 0; l < 4; l++) m_ovf[l] = 1'b0;
    end
    for (int l = 0; l < 4; l++) begin
      if (wr && ln == l) begin
        if (!m_vld[l] || dout_ready[l]) begin
          m_dat[l] = din;
          m_vld[l] = 1'b1;
        end else begin
          m_ovf[l] = 1'b1;
        end
      end else if (m_vld[l] && dout_ready[l]) begin
        m_vld[l] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic beat(input logic [7:0] d, input bit fs);
    din        = d;
    din_valid  = 1'b1;
    frame_sync = fs;
    step();
  endtask

  task automatic idle();
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    step();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    din        = 8'h00;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    dout_ready = 4'hF;
    clr_ovf    = 1'b0;
    sl1        = 1'b0;
    sl2        = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;

`ifndef DEMUX_MANUAL_SEL_EN
    // 1: hunting drops words silently
    for (int i = 0; i < 4; i++) beat(8'h10 + 8'(i), 1'b0);
    chk("t1_locked", 32'(locked), 32'h0);
    chk("t1_valid", 32'(dout_valid), 32'h0);
    chk("t1_ovf", 32'(ovf), 32'h0);

    // 2: lock and fill A..D, fifth word wraps to A
    beat(8'hA0, 1'b1);
    chk("t2_laneA", 32'(dout[7:0]), 32'hA0);
    chk("t2_locked", 32'(locked), 32'h1);
    beat(8'hA1, 1'b0);
    chk("t2_laneB", 32'(dout[15:8]), 32'hA1);
    beat(8'hA2, 1'b0);
    chk("t2_laneC", 32'(dout[23:16]), 32'hA2);
    beat(8'hA3, 1'b0);
    chk("t2_laneD", 32'(dout[31:24]), 32'hA3);
    beat(8'hA4, 1'b0);
    chk("t2_wrapA", 32'(dout[7:0]), 32'hA4);
    chk("t2_wrapA_vld", 32'(dout_valid[0]), 32'h1);

    // 3: lane B stalled over two frames
    dout_ready = 4'b1101;
    for (int i = 0; i < 8; i++) beat(8'hB0 + 8'(i), (i % 4) == 0);
    chk("t3_ovf", 32'(ovf), 32'b0010);
    chk("t3_laneB_hold", 32'(dout[15:8]), 32'hB1);
    clr_ovf = 1'b1;
    idle();
    clr_ovf = 1'b0;
    chk("t3_clr", 32'(ovf), 32'h0);
    beat(8'hC0, 1'b1);
    clr_ovf = 1'b1;
    beat(8'hC1, 1'b0);
    clr_ovf = 1'b0;
    chk("t3_set_wins", 32'(ovf), 32'b0010);

    // 4: drain and refill lane A in one cycle
    dout_ready = 4'b1100;
    beat(8'hD0, 1'b1);
    dout_ready = 4'b1101;
    beat(8'hD1, 1'b1);
    chk("t4_refill", 32'(dout[7:0]), 32'hD1);
    chk("t4_valid", 32'(dout_valid[0]), 32'h1);

    // 5: mid-frame realign, then asynchronous reset
    dout_ready = 4'hF;
    beat(8'hE0, 1'b1);
    beat(8'hE1, 1'b0);
    beat(8'hE2, 1'b1);
    chk("t5_realignA", 32'(dout[7:0]), 32'hE2);
    chk("t5_serr", 32'(sync_err), 32'h1);
    beat(8'hE3, 1'b0);
    chk("t5_nextB", 32'(dout[15:8]), 32'hE3);
    chk("t5_serr_pulse", 32'(sync_err), 32'h0);
    beat(8'hE4, 1'b0);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t5_rst_dout", dout, 32'h0);
    chk("t5_rst_locked", 32'(locked), 32'h0);
    compare_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
`else
    // 6: manual lane select
    dout_ready = 4'h0;
    idle();
    chk("t6_locked", 32'(locked), 32'h1);
    for (int i = 0; i < 4; i++) begin
      {sl1, sl2} = (i == 0) ? 2'd2 : (i == 1) ? 2'd0 : (i == 2) ? 2'd1 : 2'd3;
      beat(8'h05 + 8'(i), i[0]);
    end
    chk("t6_laneC", 32'(dout[23:16]), 32'h05);
    chk("t6_laneA", 32'(dout[7:0]), 32'h06);
    chk("t6_laneB", 32'(dout[15:8]), 32'h07);
    chk("t6_laneD", 32'(dout[31:24]), 32'h08);
    chk("t6_serr", 32'(sync_err), 32'h0);
`endif

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      din        = 8'($urandom);
      din_valid  = $urandom_range(0, 3) != 0;
      frame_sync = $urandom_range(0, 7) == 0;
      dout_ready = 4'($urandom);
      clr_ovf    = $urandom_range(0, 15) == 0;
      sl1        = 1'($urandom);
      sl2        = 1'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
